// File: rtl/dec_entry_to_bin_pkg.sv
// Shared types and constants for the decimal-entry-to-binary converter.
// Optional feature macro used by the top level: DEC_ENTRY_AUTO_CLEAR_EN.
package dec_entry_to_bin_pkg;

    localparam int NUM_DIGITS  = 5;
    localparam int OUT_W       = 16;
    localparam int ACC_W       = 17;
    localparam int CUR_W       = 3;
    localparam int MAX_POS_MAG = 32767;
    localparam int MAX_NEG_MAG = 32768;

    typedef enum logic [1:0] {
        EDIT,
        CONVERT,
        DONE
    } state_t;

    // Button commands, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_ENTER,
        BTN_SIGN,
        BTN_UP,
        BTN_DOWN,
        BTN_LEFT,
        BTN_RIGHT
    } btn_cmd_t;

    // Picks the single highest-priority button pulse; the rest are dropped.
    function automatic btn_cmd_t decode_btn(input logic enter, input logic sgn,
                                            input logic up, input logic down,
                                            input logic left, input logic right);
        if (enter)      return BTN_ENTER;
        else if (sgn)   return BTN_SIGN;
        else if (up)    return BTN_UP;
        else if (down)  return BTN_DOWN;
        else if (left)  return BTN_LEFT;
        else if (right) return BTN_RIGHT;
        else            return BTN_NONE;
    endfunction

endpackage

// File: rtl/dec_entry_to_bin_if.sv
// Button and display/result bundle between the push-button front end and
// the entry block. master = button source / result sink, slave = entry block.
interface dec_entry_to_bin_if;

    logic                                         btn_left;
    logic                                         btn_right;
    logic                                         btn_up;
    logic                                         btn_down;
    logic                                         btn_sign;
    logic                                         btn_enter;
    logic [4*dec_entry_to_bin_pkg::NUM_DIGITS-1:0] digits_bcd;
    logic                                         sign;
    logic [dec_entry_to_bin_pkg::CUR_W-1:0]       cursor;
    logic                                         busy;
    logic [dec_entry_to_bin_pkg::OUT_W-1:0]       bin_out;
    logic                                         bin_valid;
    logic                                         overflow;

    modport master (
        output btn_left, btn_right, btn_up, btn_down, btn_sign, btn_enter,
        input  digits_bcd, sign, cursor, busy, bin_out, bin_valid, overflow
    );

    modport slave (
        input  btn_left, btn_right, btn_up, btn_down, btn_sign, btn_enter,
        output digits_bcd, sign, cursor, busy, bin_out, bin_valid, overflow
    );

endinterface

// File: rtl/dec_entry_to_bin_bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per cycle, MSD first,
// acc = acc*10 + digit using shifts and adds only.
module bcd_to_bin_seq
    import dec_entry_to_bin_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    sign_i,
    output logic [ACC_W-1:0]        acc_o,
    output logic                    sign_o,
    output logic                    done_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CUR_W-1:0] idx_q;
    logic             active_q;
    logic             neg_q;
    logic [3:0]       cur_digit;

    // Multiply-by-ten-and-add of the digit currently selected by the index.
    always_comb begin
        cur_digit = digits_i[{idx_q, 2'b00} +: 4];
        acc_d     = (acc_q << 3) + (acc_q << 1) + {{(ACC_W-4){1'b0}}, cur_digit};
    end

    // Accumulator and digit index; start restarts from the MSD with a clear accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            idx_q    <= CUR_W'(NUM_DIGITS-1);
            active_q <= 1'b0;
            neg_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            idx_q    <= CUR_W'(NUM_DIGITS-1);
            active_q <= 1'b1;
            neg_q    <= sign_i;
        end else if (active_q) begin
            acc_q <= acc_d;
            if (idx_q == '0) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q - CUR_W'(1);
            end
        end
    end

    assign acc_o  = acc_q;
    assign sign_o = neg_q;
    assign done_o = active_q && (idx_q == '0);

endmodule

// File: rtl/dec_entry_to_bin.sv
// Push-button signed decimal entry with conversion to 16-bit two's complement.
// Optional: define DEC_ENTRY_AUTO_CLEAR_EN to clear the entry after a
// conversion that did not saturate.
module dec_entry_to_bin
    import dec_entry_to_bin_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dec_entry_to_bin_if.slave bus
);

    state_t                  state_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic                    sign_q;
    logic [CUR_W-1:0]        cursor_q;
    logic [OUT_W-1:0]        bin_out_q;
    logic                    bin_valid_q;
    logic                    overflow_q;

    btn_cmd_t                cmd;
    logic [3:0]              cur_digit;
    logic [3:0]              digit_inc_d;
    logic [3:0]              digit_dec_d;
    logic [OUT_W-1:0]        bin_d;
    logic                    ovf_d;
    logic                    seq_start;
    logic [ACC_W-1:0]        seq_acc;
    logic                    seq_neg;
    logic                    seq_done;

    // Button decode and the wrap-around digit step values for the cursor digit.
    always_comb begin
        cmd         = decode_btn(bus.btn_enter, bus.btn_sign, bus.btn_up,
                                 bus.btn_down, bus.btn_left, bus.btn_right);
        cur_digit   = digits_q[{cursor_q, 2'b00} +: 4];
        digit_inc_d = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
        digit_dec_d = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
        seq_start   = (state_q == EDIT) && (cmd == BTN_ENTER);
    end

    bcd_to_bin_seq u_seq (
        .clk      (clk),
        .rst      (rst),
        .start_i  (seq_start),
        .digits_i (digits_q),
        .sign_i   (sign_q),
        .acc_o    (seq_acc),
        .sign_o   (seq_neg),
        .done_o   (seq_done)
    );

    // Range check of the magnitude, then saturate or negate into OUT_W bits.
    always_comb begin
        bin_d = '0;
        ovf_d = 1'b0;
        if (!seq_neg && (seq_acc > ACC_W'(MAX_POS_MAG))) begin
            bin_d = {1'b0, {(OUT_W-1){1'b1}}};
            ovf_d = 1'b1;
        end else if (seq_neg && (seq_acc > ACC_W'(MAX_NEG_MAG))) begin
            bin_d = {1'b1, {(OUT_W-1){1'b0}}};
            ovf_d = 1'b1;
        end else if (seq_neg) begin
            bin_d = -seq_acc[OUT_W-1:0];
        end else begin
            bin_d = seq_acc[OUT_W-1:0];
        end
    end

    // Edit FSM: button handling in EDIT, wait for the converter, publish in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EDIT;
            digits_q    <= '0;
            sign_q      <= 1'b0;
            cursor_q    <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            bin_valid_q <= 1'b0;
            case (state_q)
                EDIT: begin
                    case (cmd)
                        BTN_ENTER: state_q <= CONVERT;
                        BTN_SIGN:  sign_q  <= ~sign_q;
                        BTN_UP:    digits_q[{cursor_q, 2'b00} +: 4] <= digit_inc_d;
                        BTN_DOWN:  digits_q[{cursor_q, 2'b00} +: 4] <= digit_dec_d;
                        BTN_LEFT: begin
                            if (cursor_q != CUR_W'(NUM_DIGITS-1)) begin
                                cursor_q <= cursor_q + CUR_W'(1);
                            end
                        end
                        BTN_RIGHT: begin
                            if (cursor_q != '0) begin
                                cursor_q <= cursor_q - CUR_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                CONVERT: begin
                    if (seq_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bin_out_q   <= bin_d;
                    overflow_q  <= ovf_d;
                    bin_valid_q <= 1'b1;
                    state_q     <= EDIT;
`ifdef DEC_ENTRY_AUTO_CLEAR_EN
                    if (!ovf_d) begin
                        digits_q <= '0;
                        sign_q   <= 1'b0;
                        cursor_q <= '0;
                    end
`endif
                end
                default: state_q <= EDIT;
            endcase
        end
    end

    assign bus.digits_bcd = digits_q;
    assign bus.sign       = sign_q;
    assign bus.cursor     = cursor_q;
    assign bus.busy       = (state_q != EDIT);
    assign bus.bin_out    = bin_out_q;
    assign bus.bin_valid  = bin_valid_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_dec_entry_to_bin.sv
// Self-checking bench for dec_entry_to_bin: directed button sequences, with
// conversion results checked through an expected-value queue by a monitor.
module tb_dec_entry_to_bin;

    localparam logic [5:0] B_ENTER = 6'b100000;
    localparam logic [5:0] B_SIGN  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    logic [16:0] sb[$];

    dec_entry_to_bin_if bus ();

    dec_entry_to_bin dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One-cycle pulse on the selected buttons, sampled by the next rising edge.
    task automatic applyStimulus(input logic [5:0] b);
        @(posedge clk);
        #1;
        {bus.btn_enter, bus.btn_sign, bus.btn_up, bus.btn_down,
         bus.btn_left, bus.btn_right} = b;
        @(posedge clk);
        #1;
        {bus.btn_enter, bus.btn_sign, bus.btn_up, bus.btn_down,
         bus.btn_left, bus.btn_right} = 6'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Keys in a value from a cleared entry: LSD first, moving left.
    task automatic loadEntry(input logic [19:0] val, input logic neg);
        logic [3:0] d;
        for (int p = 0; p < 5; p++) begin
            d = val[p*4 +: 4];
            for (int k = 0; k < int'(d); k++) applyStimulus(B_UP);
            if (p < 4) applyStimulus(B_LEFT);
        end
        if (neg) applyStimulus(B_SIGN);
        checkOutput("entry digits", {12'b0, bus.digits_bcd}, {12'b0, val});
        checkOutput("entry sign", {31'b0, bus.sign}, {31'b0, neg});
    endtask

    // Queue the expected result, press enter and wait (bounded) for bin_valid.
    task automatic runConversion(input logic [15:0] expBin, input logic expOvf,
                                 input bit checkTiming, input bit inject,
                                 input logic [19:0] frozenDigits);
        int cycles;
        int busyCycles;
        bit seen;
        sb.push_back({expOvf, expBin});
        applyStimulus(B_ENTER);
        cycles = 0;
        busyCycles = 0;
        seen = 0;
        if (inject) begin
            applyStimulus(B_UP | B_SIGN);
            checkOutput("frozen digits", {12'b0, bus.digits_bcd}, {12'b0, frozenDigits});
            checkOutput("frozen sign", {31'b0, bus.sign}, 32'd0);
            checkOutput("busy during convert", {31'b0, bus.busy}, 32'd1);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.bin_valid) begin
                seen = 1;
            end else begin
                cycles++;
                if (bus.busy) busyCycles++;
            end
        end
        if (!seen) begin
            failCount++;
            $display("[TB] FAIL valid timeout: got no bin_valid expected pulse within 20 cycles");
        end
        if (checkTiming) begin
            checkOutput("enter-to-valid latency", cycles, 32'd6);
            checkOutput("busy cycles", busyCycles, 32'd6);
        end
    endtask

    // Monitor: every bin_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [16:0] exp;
        if (rst && bus.bin_valid) begin
            if (sb.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected valid: got bin_out %0h expected no pulse",
                         bus.bin_out);
            end else begin
                exp = sb.pop_front();
                checkOutput("bin_out", {16'b0, bus.bin_out}, {16'b0, exp[15:0]});
                checkOutput("overflow", {31'b0, bus.overflow}, {31'b0, exp[16]});
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int validCount;
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1;
        {bus.btn_enter, bus.btn_sign, bus.btn_up, bus.btn_down,
         bus.btn_left, bus.btn_right} = 6'b0;

        $display("[TB] reset values");
        doReset();
        checkOutput("reset digits", {12'b0, bus.digits_bcd}, 32'd0);
        checkOutput("reset sign", {31'b0, bus.sign}, 32'd0);
        checkOutput("reset cursor", {29'b0, bus.cursor}, 32'd0);
        checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("reset bin_out", {16'b0, bus.bin_out}, 32'd0);
        checkOutput("reset valid", {31'b0, bus.bin_valid}, 32'd0);
        checkOutput("reset overflow", {31'b0, bus.overflow}, 32'd0);

        $display("[TB] digit and cursor limits");
        applyStimulus(B_DOWN);
        checkOutput("down wraps 0 to 9", {12'b0, bus.digits_bcd}, 32'h00009);
        applyStimulus(B_UP);
        checkOutput("up wraps 9 to 0", {12'b0, bus.digits_bcd}, 32'h00000);
        applyStimulus(B_RIGHT);
        checkOutput("right at 0", {29'b0, bus.cursor}, 32'd0);
        applyStimulus(B_UP | B_LEFT);
        checkOutput("up+left digits", {12'b0, bus.digits_bcd}, 32'h00001);
        checkOutput("up+left cursor", {29'b0, bus.cursor}, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(B_LEFT);
        checkOutput("six lefts", {29'b0, bus.cursor}, 32'd4);
        applyStimulus(B_SIGN);
        checkOutput("sign toggle on", {31'b0, bus.sign}, 32'd1);
        applyStimulus(B_SIGN | B_DOWN);
        checkOutput("sign over down", {31'b0, bus.sign}, 32'd0);
        checkOutput("down dropped", {12'b0, bus.digits_bcd}, 32'h00001);

        $display("[TB] 12345 positive");
        doReset();
        loadEntry(20'h12345, 1'b0);
        runConversion(16'h3039, 1'b0, 1'b1, 1'b0, 20'h0);
`ifdef DEC_ENTRY_AUTO_CLEAR_EN
        checkOutput("auto clear digits", {12'b0, bus.digits_bcd}, 32'h00000);
        checkOutput("auto clear cursor", {29'b0, bus.cursor}, 32'd0);
`else
        checkOutput("retained digits", {12'b0, bus.digits_bcd}, 32'h12345);
        checkOutput("retained cursor", {29'b0, bus.cursor}, 32'd4);
`endif

        $display("[TB] saturation boundaries");
        doReset();
        loadEntry(20'h32768, 1'b1);
        runConversion(16'h8000, 1'b0, 1'b0, 1'b0, 20'h0);
        doReset();
        loadEntry(20'h32768, 1'b0);
        runConversion(16'h7FFF, 1'b1, 1'b0, 1'b0, 20'h0);
        checkOutput("entry kept on overflow", {12'b0, bus.digits_bcd}, 32'h32768);
        doReset();
        loadEntry(20'h32767, 1'b0);
        runConversion(16'h7FFF, 1'b0, 1'b0, 1'b0, 20'h0);
        doReset();
        loadEntry(20'h99999, 1'b1);
        runConversion(16'h8000, 1'b1, 1'b0, 1'b0, 20'h0);
        doReset();
        loadEntry(20'h00000, 1'b1);
        runConversion(16'h0000, 1'b0, 1'b0, 1'b0, 20'h0);
        doReset();
        loadEntry(20'h00005, 1'b1);
        runConversion(16'hFFFB, 1'b0, 1'b0, 1'b0, 20'h0);

        $display("[TB] buttons ignored while converting");
        doReset();
        loadEntry(20'h00123, 1'b0);
        runConversion(16'h007B, 1'b0, 1'b0, 1'b1, 20'h00123);

        $display("[TB] reset mid-conversion");
        doReset();
        loadEntry(20'h00042, 1'b0);
        runConversion(16'h002A, 1'b0, 1'b0, 1'b0, 20'h0);
        applyStimulus(B_ENTER);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        checkOutput("midreset bin_out", {16'b0, bus.bin_out}, 32'd0);
        checkOutput("midreset busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("midreset valid", {31'b0, bus.bin_valid}, 32'd0);
        checkOutput("midreset digits", {12'b0, bus.digits_bcd}, 32'd0);
        checkOutput("midreset cursor", {29'b0, bus.cursor}, 32'd0);
        checkOutput("midreset overflow", {31'b0, bus.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        validCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.bin_valid) validCount++;
        end
        checkOutput("no valid after reset", validCount, 32'd0);

        checkOutput("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dec_entry_to_bin.md
Name: dec_entry_to_bin

Overview:
- Reverse path of the signed binary-to-7-segment display: the operator keys in a signed 5-digit decimal number with push buttons, and the block produces a 16-bit two's-complement value.
- Holds five BCD digits, a sign bit and a cursor, all exported for the existing 7-segment display path.
- On ENTER, converts the digits to binary with a sequential multiply-by-10-and-add, then range-checks and saturates the result.
- Sits between the PushButton_Detector instances (one-cycle pulses) and downstream arithmetic such as the signed SPM operand registers.

Parameters:
- NUM_DIGITS, 5, number of BCD digits edited and converted.
- OUT_W, 16, width of the signed binary result.
- ACC_W, 17, accumulator width; must hold 10^NUM_DIGITS-1 (99999).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_left  in  1  one-cycle pulse; moves cursor toward the MSD.
- btn_right  in  1  one-cycle pulse; moves cursor toward the LSD.
- btn_up  in  1  one-cycle pulse; increments the digit under the cursor.
- btn_down  in  1  one-cycle pulse; decrements the digit under the cursor.
- btn_sign  in  1  one-cycle pulse; toggles the sign.
- btn_enter  in  1  one-cycle pulse; starts conversion.
- digits_bcd  out  4*NUM_DIGITS  current digits; digit 4 (MSD) in [19:16], digit 0 in [3:0].
- sign  out  1  1 = negative.
- cursor  out  3  index of the digit being edited, range 0..NUM_DIGITS-1.
- busy  out  1  high in the CONVERT and DONE states.
- bin_out  out  OUT_W  last converted value; held between conversions.
- bin_valid  out  1  one-cycle pulse when bin_out updates.
- overflow  out  1  saturation flag for the last conversion; held until the next conversion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=EDIT.
  - All digits=0, sign=0, cursor=0.
  - bin_out=0, bin_valid=0, overflow=0, busy=0, accumulator=0, digit index=NUM_DIGITS-1.
- EDIT state, per-cycle handling:
  - At most one button is acted on per cycle. Priority: enter > sign > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
  - left: cursor+1, saturating at NUM_DIGITS-1.
  - right: cursor-1, saturating at 0.
  - up: digit = digit==9 ? 0 : digit+1.
  - down: digit = digit==0 ? 9 : digit-1.
  - sign: sign toggles.
  - enter: accumulator cleared, index = NUM_DIGITS-1, state goes to CONVERT, busy rises next cycle.
- CONVERT state:
  - One digit per cycle, MSD first: acc <= acc*10 + digit[index].
  - acc*10 is formed as (acc<<3)+(acc<<1) in ACC_W bits; no multiplier is used.
  - After index 0 is processed (NUM_DIGITS cycles total), state goes to DONE.
- DONE state (exactly one cycle):
  - sign=0 and acc>32767: bin_out=16'h7FFF, overflow=1.
  - sign=1 and acc>32768: bin_out=16'h8000, overflow=1.
  - Otherwise: bin_out = sign ? -acc : acc (truncated to OUT_W), overflow=0.
  - -0 yields 16'h0000 with overflow=0.
  - -32768 yields 16'h8000 with overflow=0.
  - bin_valid=1 for this cycle only; next state is EDIT.
- Latency: btn_enter sampled at edge t gives bin_valid high in the cycle after edge t+NUM_DIGITS+1 (6 cycles for the default).
- During CONVERT and DONE, all button pulses are ignored, not queued. Digits, sign and cursor are frozen.
- Reset mid-conversion: immediate return to reset values. No bin_valid is produced and bin_out returns to 0.
- The digits_bcd, sign and cursor outputs are registered, with no combinational path from the buttons.

Optional Feature:
- Macro: DEC_ENTRY_AUTO_CLEAR_EN.
- Defined: in the DONE cycle, if overflow=0, digits, sign and cursor return to 0 (fresh entry). On overflow, the entry is retained so the operator can correct it.
- Undefined: the entry is always retained after conversion for incremental editing.

Decomposition:
- Shared package:
  - State enum {EDIT, CONVERT, DONE}.
  - Constants NUM_DIGITS, OUT_W, ACC_W.
  - MAX_POS_MAG=32767 and MAX_NEG_MAG=32768.
  - Priority-order constants for the button decode.
- Sub-module bcd_to_bin_seq: the accumulator, the digit index, the x10+add datapath and the done strobe, with inputs start, digits and sign.
- The top level holds the edit FSM, cursor/digit/sign registers and the saturation/negation stage.

Test Plan:
- Set digits 1,2,3,4,5 via up/left, sign=0, pulse enter at edge t → busy high for 6 cycles; bin_valid one cycle after edge t+6; bin_out=16'h3039; overflow=0.
- Enter 32768 with sign=1 → bin_out=16'h8000, overflow=0. Enter 32768 with sign=0 → bin_out=16'h7FFF, overflow=1.
- Enter 99999 with sign=1 → bin_out=16'h8000, overflow=1. Enter 00000 with sign=1 → bin_out=16'h0000, overflow=0.
- Digit and cursor limits:
  - Down on a 0 digit → 9; up on a 9 → 0.
  - Six lefts from cursor 0 → cursor 4; right at cursor 0 → stays 0.
  - up+left in the same cycle → only the increment occurs.
- Press up and sign during CONVERT → digits and sign unchanged, and bin_out matches the pre-press entry.
- Assert rst low 3 cycles after enter → bin_valid never pulses; all outputs read reset values; with DEC_ENTRY_AUTO_CLEAR_EN, a valid conversion clears digits to 0 in the DONE cycle.
